enc_width_converter_arbiter: RTL and testbench
==============================================

ENC_WIDTH_CONVERTER_ARBITER -- requirements
Module: enc_width_converter_arbiter

Interface
REQ-001 The block SHALL have parameter DataWidth, default 32, width of each requester word and of the converter input.
REQ-002 The block SHALL have parameter NumChannels, default 4, fixed at 4; channel ID is 2 bits.
REQ-003 The block SHALL have port iClock  input  1  clock; all logic rising-edge.
REQ-004 The block SHALL have port iReset  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port iReqValid  input  4  per-channel word valid.
REQ-006 The block SHALL have port iReqLast  input  4  per-channel last word of burst.
REQ-007 The block SHALL have port iReqData  input  4*DataWidth  channel n word at bits [n*DataWidth +: DataWidth].
REQ-008 The block SHALL have port oReqReady  output  4  per-channel word accepted when valid and ready are both high.
REQ-009 The block SHALL have port oSrcDataValid  output  1  word valid to converter.
REQ-010 The block SHALL have port oSrcDataLast  output  1  last word to converter.
REQ-011 The block SHALL have port oSrcData  output  DataWidth  word to converter.
REQ-012 The block SHALL have port iConverterReady  input  1  converter accepts the word this cycle.
REQ-013 The block SHALL have port iConvertedLastAccepted  input  1  pulse when the converter's last 16-bit beat is taken downstream.
REQ-014 The block SHALL have port oGrantChannel  output  2  currently owning channel, registered.
REQ-015 The block SHALL have port oBusy  output  1  high in Forward or Drain.
REQ-016 The block SHALL have port oBeatCount  output  8  words accepted in current/last burst, saturating at 255.

Function
REQ-017 The block SHALL implement states Idle, Forward and Drain, one-hot encoded.
REQ-018 In Idle with any iReqValid high, the block SHALL register a round-robin grant: first valid channel at or after pointer, wrapping 3->0, then enter Forward.
REQ-019 The grant decision SHALL take exactly one cycle; no word SHALL be forwarded in the Idle cycle.
REQ-020 In Forward, oSrcDataValid/oSrcDataLast/oSrcData SHALL be the granted channel's inputs, combinational, zero added latency.
REQ-021 In Forward, oReqReady[grant] SHALL equal iConverterReady; all other oReqReady bits SHALL be 0.
REQ-022 Outside Forward, oSrcDataValid and all oReqReady bits SHALL be 0; oSrcData SHALL hold the granted channel's word.
REQ-023 Grant SHALL persist until the granted channel's last-word handshake (valid, ready, last all high); then the next state SHALL be Drain.
REQ-024 In Drain, iConvertedLastAccepted high SHALL move the block to Idle and set pointer to grant+1 modulo 4.
REQ-025 iConvertedLastAccepted SHALL be ignored outside Drain.
REQ-026 oBeatCount SHALL clear on grant, increment per accepted word in Forward, saturate at 255, hold through Drain and Idle.
REQ-027 A granted channel deasserting valid mid-burst SHALL stall the burst without releasing the grant.
REQ-028 Requests from non-granted channels SHALL never be accepted, regardless of valid.

Reset
REQ-029 iReset SHALL force Idle, pointer 0, oGrantChannel 0, oBeatCount 0, oBusy 0, oReqReady 0, oSrcDataValid 0, oSrcDataLast 0, from any state including mid-burst.
REQ-030 Reset SHALL take precedence over every simultaneous event.

Configuration
REQ-031 With macro ENC_ARB_PRIO0_EN defined, channel 0 SHALL win every Idle grant decision when iReqValid[0] is high, regardless of pointer; others remain round-robin.
REQ-032 Without ENC_ARB_PRIO0_EN, all four channels SHALL be strictly round-robin per REQ-018.

Verification
REQ-033 Reset, then iReqValid=4'b1111 continuously, each burst 2 words with last on word 2, Drain pulse 3 cycles after last -> grant order 0,1,2,3,0; oBeatCount=2 after each burst.
REQ-034 Channel 2 alone, 3-word burst, iConverterReady toggling 1,0,1,0 -> exactly 3 handshakes, oReqReady only on bit 2, oSrcData matches channel 2 words in order.
REQ-035 Channel 1 burst of 300 words -> oBeatCount saturates at 255, grant held until last, then Drain.
REQ-036 iReset asserted in Forward after 1 of 4 words -> next cycle Idle, all outputs 0, pointer 0; next request from channel 3 is granted.
REQ-037 iConvertedLastAccepted pulsed in Idle and Forward -> no state change; pulse in Drain -> Idle next cycle.
REQ-038 With ENC_ARB_PRIO0_EN, pointer=2, iReqValid=4'b0101 -> channel 0 granted; without macro -> channel 2 granted.

Source files
------------

// File: rtl/enc_width_converter_arbiter.sv
// Four-channel round-robin arbiter feeding a width converter: grant, forward one burst, wait for drain.
// Optional macro ENC_ARB_PRIO0_EN makes channel 0 win every grant decision it requests.
module enc_width_converter_arbiter #(
    parameter int DataWidth   = 32,
    parameter int NumChannels = 4
) (
    input  logic                             iClock,
    input  logic                             iReset,
    input  logic [NumChannels-1:0]           iReqValid,
    input  logic [NumChannels-1:0]           iReqLast,
    input  logic [NumChannels*DataWidth-1:0] iReqData,
    output logic [NumChannels-1:0]           oReqReady,
    output logic                             oSrcDataValid,
    output logic                             oSrcDataLast,
    output logic [DataWidth-1:0]             oSrcData,
    input  logic                             iConverterReady,
    input  logic                             iConvertedLastAccepted,
    output logic [1:0]                       oGrantChannel,
    output logic                             oBusy,
    output logic [7:0]                       oBeatCount
);

    localparam logic [2:0] StIdle    = 3'b001;
    localparam logic [2:0] StForward = 3'b010;
    localparam logic [2:0] StDrain   = 3'b100;

    logic [2:0] state;
    logic [1:0] pointer;
    logic [1:0] nextGrant;
    logic       forwardActive;
    logic       wordAccepted;

    // Reset gates the handshake so a word can never be taken in the cycle reset lands.
    assign forwardActive = (state == StForward) && !iReset;
    assign wordAccepted  = forwardActive && iReqValid[oGrantChannel] && iConverterReady;

    assign oSrcData      = iReqData[oGrantChannel*DataWidth +: DataWidth];
    assign oSrcDataValid = forwardActive && iReqValid[oGrantChannel];
    assign oSrcDataLast  = forwardActive && iReqLast[oGrantChannel];
    assign oBusy         = (state == StForward) || (state == StDrain);

    always_comb begin
        // NOTE: default assignment first keeps this combinational block latch-free.
        oReqReady = '0;
        if (forwardActive) begin
            oReqReady[oGrantChannel] = iConverterReady;
        end
    end

    // Scanning from the farthest offset down lets the nearest valid channel win last.
    always_comb begin
        nextGrant = pointer;
        for (int k = NumChannels - 1; k >= 0; k--) begin
            if (iReqValid[pointer + 2'(k)]) begin
                nextGrant = pointer + 2'(k);
            end
        end
`ifdef ENC_ARB_PRIO0_EN
        if (iReqValid[0]) begin
            nextGrant = 2'd0;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state         <= StIdle;
            pointer       <= 2'd0;
            oGrantChannel <= 2'd0;
            oBeatCount    <= 8'd0;
        end else begin
            case (state)
                StIdle: begin
                    if (|iReqValid) begin
                        oGrantChannel <= nextGrant;
                        oBeatCount    <= 8'd0;
                        state         <= StForward;
                    end
                end
                StForward: begin
                    if (wordAccepted) begin
                        if (oBeatCount != 8'hFF) begin
                            oBeatCount <= oBeatCount + 8'd1;
                        end
                        if (iReqLast[oGrantChannel]) begin
                            state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (iConvertedLastAccepted) begin
                        state   <= StIdle;
                        pointer <= oGrantChannel + 2'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_enc_width_converter_arbiter.sv
// Randomised and directed bench for enc_width_converter_arbiter against a transaction-level model.
module tb_enc_width_converter_arbiter;

    localparam int DW = 32;

    logic          iClock = 1'b0;
    logic          iReset = 1'b1;
    logic [3:0]    iReqValid = '0;
    logic [3:0]    iReqLast = '0;
    logic [4*DW-1:0] iReqData = '0;
    logic [3:0]    oReqReady;
    logic          oSrcDataValid;
    logic          oSrcDataLast;
    logic [DW-1:0] oSrcData;
    logic          iConverterReady = 1'b0;
    logic          iConvertedLastAccepted = 1'b0;
    logic [1:0]    oGrantChannel;
    logic          oBusy;
    logic [7:0]    oBeatCount;

    enc_width_converter_arbiter #(.DataWidth(DW), .NumChannels(4)) dut (
        .iClock(iClock),
        .iReset(iReset),
        .iReqValid(iReqValid),
        .iReqLast(iReqLast),
        .iReqData(iReqData),
        .oReqReady(oReqReady),
        .oSrcDataValid(oSrcDataValid),
        .oSrcDataLast(oSrcDataLast),
        .oSrcData(oSrcData),
        .iConverterReady(iConverterReady),
        .iConvertedLastAccepted(iConvertedLastAccepted),
        .oGrantChannel(oGrantChannel),
        .oBusy(oBusy),
        .oBeatCount(oBeatCount)
    );

    always #5 iClock = ~iClock;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- transaction-level model ----------------
    // phase: 0 waiting for requests, 1 owner streaming its burst, 2 waiting for drain
    int mPhase = 0, mOwner = 0, mNext = 0, mCount = 0, mDrains = 0;
    int grantLog[$];
    int beatLog[$];
    logic [DW-1:0] accLog[$];

    function automatic int pickOwner(logic [3:0] v, int start);
`ifdef ENC_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (v[(start + k) % 4]) return (start + k) % 4;
        end
        return start;
    endfunction

    always @(posedge iClock) begin
        if (iReset) begin
            mPhase = 0; mNext = 0; mOwner = 0; mCount = 0;
        end else if (mPhase == 0) begin
            if (iReqValid != 4'b0) begin
                mOwner = pickOwner(iReqValid, mNext);
                mCount = 0;
                mPhase = 1;
                grantLog.push_back(mOwner);
            end
        end else if (mPhase == 1) begin
            if (iReqValid[mOwner] && iConverterReady) begin
                accLog.push_back(iReqData[mOwner*DW +: DW]);
                mCount = (mCount >= 255) ? 255 : mCount + 1;
                if (iReqLast[mOwner]) begin
                    mPhase = 2;
                    beatLog.push_back(mCount);
                end
            end
        end else begin
            if (iConvertedLastAccepted) begin
                mPhase = 0;
                mNext = (mOwner + 1) % 4;
                mDrains++;
            end
        end
    end

    // ---------------- checking ----------------
    int nChecks = 0, nErrors = 0;
    bit checking = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        bit fwd;
        logic [3:0] expReady;
        fwd = (mPhase == 1) && !iReset;
        expReady = '0;
        if (fwd && iConverterReady) expReady[mOwner] = 1'b1;
        check("grant", 64'(oGrantChannel), 64'(mOwner));
        check("busy", 64'(oBusy), 64'(mPhase != 0));
        check("beat", 64'(oBeatCount), 64'(mCount));
        check("ready", 64'(oReqReady), 64'(expReady));
        check("srcValid", 64'(oSrcDataValid), 64'(fwd && iReqValid[mOwner]));
        check("srcLast", 64'(oSrcDataLast), 64'(fwd && iReqLast[mOwner]));
        check("srcData", 64'(oSrcData), 64'(iReqData[mOwner*DW +: DW]));
    endtask

    // ---------------- stimulus ----------------
    int words[4] = '{0, 0, 0, 0};
    int blen[4]  = '{1, 1, 1, 1};
    int pos[4]   = '{0, 0, 0, 0};
    int sent[4]  = '{0, 0, 0, 0};
    int readyMode = 0;      // 0 always ready, 1 toggle, 2 random
    bit randValid = 0, randPulse = 0, autoDrain = 1, extraPulse = 0;
    int drainDelay = 3, drainCd = 0;

    function automatic logic [DW-1:0] dataWord(int c, int k);
        logic [31:0] cc;
        cc = 32'(c);
        return {cc[3:0], 28'(k * 1009 + 7)};
    endfunction

    task automatic step();
        logic [3:0] hs;
        bit lastHs, pulse;
        @(negedge iClock);
        if (checking) compareAll();
        hs = '0;
        lastHs = 0;
        if (mPhase == 1 && !iReset && iReqValid[mOwner] && iConverterReady) begin
            hs[mOwner] = 1'b1;
            lastHs = iReqLast[mOwner];
        end
        @(posedge iClock);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (hs[c]) begin
                words[c]--;
                sent[c]++;
                pos[c] = (pos[c] + 1) % blen[c];
            end
        end
        if (lastHs && autoDrain) drainCd = drainDelay;
        pulse = 0;
        if (drainCd > 0) begin
            drainCd--;
            if (drainCd == 0) pulse = 1;
        end
        if (extraPulse) begin
            pulse = 1;
            extraPulse = 0;
        end
        if (randPulse && ($urandom % 16 == 0)) pulse = 1;
        iConvertedLastAccepted = pulse;
        for (int c = 0; c < 4; c++) begin
            iReqValid[c] = (words[c] > 0) && !(randValid && ($urandom % 3 == 0));
            iReqLast[c] = (pos[c] == blen[c] - 1);
            iReqData[c*DW +: DW] = dataWord(c, sent[c]);
        end
        case (readyMode)
            0: iConverterReady = 1'b1;
            1: iConverterReady = ~iConverterReady;
            default: iConverterReady = 1'($urandom);
        endcase
    endtask

    task automatic waitDrains(input string name, input int target, input int bound);
        int n = 0;
        while (mDrains < target && n < bound) begin
            step();
            n++;
        end
        check(name, 64'(mDrains >= target), 64'd1);
    endtask

    task automatic waitIdle(input string name, input int bound);
        int n = 0;
        while (!(words[0] == 0 && words[1] == 0 && words[2] == 0 && words[3] == 0 && mPhase == 0)
               && n < bound) begin
            step();
            n++;
        end
        check(name, 64'(mPhase), 64'd0);
    endtask

    initial begin
        int g0, b0, a0, s0, n;
        int expOrder[5] = '{0, 1, 2, 3, 0};

        // reset
        iReset = 1;
        step();
        checking = 1;
        step();
        step();
        iReset = 0;
        step();
        check("rst_grant", 64'(oGrantChannel), 64'd0);
        check("rst_busy", 64'(oBusy), 64'd0);
        check("rst_beat", 64'(oBeatCount), 64'd0);
        check("rst_ready", 64'(oReqReady), 64'd0);
        check("rst_valid", 64'(oSrcDataValid), 64'd0);

        // all four channels requesting, two-word bursts
        g0 = grantLog.size();
        b0 = beatLog.size();
        for (int c = 0; c < 4; c++) begin
            blen[c] = 2;
            words[c] = (c == 0) ? 4 : 2;
        end
        waitDrains("rr_drains", mDrains + 5, 300);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr_order%0d", i), 64'(grantLog[g0 + i]), 64'(expOrder[i]));
            check($sformatf("rr_beats%0d", i), 64'(beatLog[b0 + i]), 64'd2);
        end
        waitIdle("rr_idle", 50);

        // channel 2 alone, converter ready toggling
        a0 = accLog.size();
        s0 = sent[2];
        readyMode = 1;
        blen[2] = 3;
        words[2] = 3;
        waitDrains("tog_drain", mDrains + 1, 60);
        check("tog_count", 64'(accLog.size() - a0), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("tog_data%0d", i), 64'(accLog[a0 + i]), 64'(dataWord(2, s0 + i)));
        end
        check("tog_beat", 64'(oBeatCount), 64'd3);
        readyMode = 0;

        // channel 1, 300-word burst saturates the beat counter
        g0 = grantLog.size();
        blen[1] = 300;
        words[1] = 300;
        waitDrains("long_drain", mDrains + 1, 400);
        check("long_beat_model", 64'(beatLog[beatLog.size() - 1]), 64'd255);
        check("long_beat", 64'(oBeatCount), 64'd255);
        check("long_grants", 64'(grantLog.size() - g0), 64'd1);

        // random traffic with stalls, random ready, stray drain pulses
        readyMode = 2;
        randValid = 1;
        randPulse = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (words[c] == 0 && ($urandom % 8 == 0)) begin
                    blen[c] = $urandom_range(1, 4);
                    words[c] = blen[c] * $urandom_range(1, 2);
                    pos[c] = 0;
                end
            end
            drainDelay = $urandom_range(1, 4);
            step();
        end
        randValid = 0;
        randPulse = 0;
        readyMode = 0;
        drainDelay = 3;
        waitIdle("rand_idle", 500);

        // drain pulse ignored in Idle and Forward, honoured in Drain
        autoDrain = 0;
        blen[0] = 2;
        words[0] = 2;
        pos[0] = 0;
        extraPulse = 1;
        step();
        step();
        extraPulse = 1;
        step();
        step();
        check("pulse_fwd_busy", 64'(oBusy), 64'd1);
        check("pulse_fwd_grant", 64'(oGrantChannel), 64'd0);
        step();
        step();
        check("drain_hold_busy", 64'(oBusy), 64'd1);
        extraPulse = 1;
        step();
        step();
        check("drain_exit_busy", 64'(oBusy), 64'd0);
        autoDrain = 1;

        // reset in the middle of a burst
        blen[1] = 4;
        words[1] = 4;
        pos[1] = 0;
        n = 0;
        while (!(mPhase == 1 && mCount == 1) && n < 30) begin
            step();
            n++;
        end
        check("mid_reached", 64'(mCount), 64'd1);
        iReset = 1;
        for (int c = 0; c < 4; c++) begin
            words[c] = 0;
            pos[c] = 0;
        end
        drainCd = 0;
        step();
        iReset = 0;
        check("mrst_ready", 64'(oReqReady), 64'd0);
        check("mrst_valid", 64'(oSrcDataValid), 64'd0);
        check("mrst_last", 64'(oSrcDataLast), 64'd0);
        check("mrst_busy", 64'(oBusy), 64'd0);
        check("mrst_grant", 64'(oGrantChannel), 64'd0);
        check("mrst_beat", 64'(oBeatCount), 64'd0);
        blen[3] = 1;
        words[3] = 1;
        waitDrains("mrst_drain", mDrains + 1, 30);
        check("mrst_next", 64'(grantLog[grantLog.size() - 1]), 64'd3);

        // pointer at 2, channels 0 and 2 request together
        blen[1] = 1;
        words[1] = 1;
        waitDrains("ptr_drain", mDrains + 1, 30);
        g0 = grantLog.size();
        blen[0] = 1;
        words[0] = 1;
        blen[2] = 1;
        words[2] = 1;
        n = 0;
        while (grantLog.size() == g0 && n < 10) begin
            step();
            n++;
        end
`ifdef ENC_ARB_PRIO0_EN
        check("prio_grant", 64'(grantLog[g0]), 64'd0);
`else
        check("prio_grant", 64'(grantLog[g0]), 64'd2);
`endif
        step();
        step();
`ifdef ENC_ARB_PRIO0_EN
        check("prio_dut_grant", 64'(oGrantChannel), 64'd0);
`else
        check("prio_dut_grant", 64'(oGrantChannel), 64'd2);
`endif
        waitIdle("final_idle", 100);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
